// File: rtl/design1_wrapper.sv
// design1_wrapper: board-level wrapper for the FSIC SoC evaluation platform.
// Holds the system reset controller, a firmware-boot model that reports
// "firmware running" on the user GPIO bus, and an AXI4-Lite register block.
//
// Ports:
//   sys_clock        sole clock
//   sys_reset        asynchronous active-low system reset
//   resetb_0         active-low core reset (async assert, synchronized release)
//   s_axi_aw*/w*/b*  AXI4-Lite write address / data / response channels
//   s_axi_ar*/r*     AXI4-Lite read address / data channels
//   mprj_o           user-project GPIO: [37:36] boot done, [1:0] CTRL
//   periph_aresetn   synchronized peripheral reset
module design1_wrapper #(
  parameter logic [31:0] BASE_ADDR   = 32'h6000_0000,
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned BOOT_CYCLES = 1000
) (
  input  logic        sys_clock,
  input  logic        sys_reset,
  input  logic        resetb_0,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [37:0] mprj_o,
  output logic        periph_aresetn
);

  localparam int unsigned RCW = $clog2(RST_HOLD + 2);
  localparam int unsigned BCW = $clog2(BOOT_CYCLES + 2);
  localparam logic [15:0] OFF_CTRL   = 16'h7000;
  localparam logic [15:0] OFF_STATUS = 16'h5000;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  // ---------------- reset controller ----------------
  logic [1:0]     r_rst_sync;
  logic [RCW-1:0] r_rst_cnt;
  logic           r_periph_aresetn;

  // 2-flop synchronizer on sys_reset release, then RST_HOLD cycles of hold-off
  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      r_rst_sync       <= '0;
      r_rst_cnt        <= '0;
      r_periph_aresetn <= 1'b0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
      if (r_rst_sync[1] && !r_periph_aresetn) begin
        r_rst_cnt <= r_rst_cnt + RCW'(1);
        if (r_rst_cnt == RCW'(RST_HOLD - 1)) r_periph_aresetn <= 1'b1;
      end
    end
  end

  // ---------------- core reset ----------------
  logic [1:0] r_core_sync;
  logic       w_core_rst_n;

  // asserts immediately with resetb_0, releases two clocks later
  always_ff @(posedge sys_clock or negedge resetb_0) begin
    if (!resetb_0) r_core_sync <= '0;
    else           r_core_sync <= {r_core_sync[0], 1'b1};
  end

  assign w_core_rst_n = r_core_sync[1] & r_periph_aresetn;

  // ---------------- boot model ----------------
  logic [BCW-1:0] r_boot_cnt;
  logic           r_boot_done;

  // counts core-reset-free cycles; boot_done is sticky until core reset
  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      r_boot_cnt  <= '0;
      r_boot_done <= 1'b0;
    end else if (!w_core_rst_n) begin
      r_boot_cnt  <= '0;
      r_boot_done <= 1'b0;
    end else if (!r_boot_done) begin
      r_boot_cnt <= r_boot_cnt + BCW'(1);
      if (r_boot_cnt == BCW'(BOOT_CYCLES - 1)) r_boot_done <= 1'b1;
    end
  end

  // ---------------- AXI4-Lite register block ----------------
  logic        r_aw_full, r_w_full, r_wstrb0;
  logic [31:0] r_awaddr;
  logic [1:0]  r_wdata, r_ctrl;
  logic        r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]  r_bresp, r_rresp;
  logic [31:0] r_rdata;

  logic        w_aw_full_n, w_w_full_n, w_wstrb0_n;
  logic [31:0] w_awaddr_n;
  logic [1:0]  w_wdata_n, w_ctrl_n;
  logic        w_awready_n, w_wready_n, w_bvalid_n, w_arready_n, w_rvalid_n;
  logic [1:0]  w_bresp_n, w_rresp_n;
  logic [31:0] w_rdata_n;
  logic        w_unused;

  assign w_unused = ^{s_axi_wdata[31:2], s_axi_wstrb[3:1]};

  function automatic logic f_in_win(input logic [31:0] a);
    return a[31:16] == BASE_ADDR[31:16];
  endfunction

  function automatic logic [1:0] f_resp(input logic [31:0] a);
    if (!f_in_win(a))                                return RESP_DECERR;
    else if (a[15:0] == OFF_CTRL || a[15:0] == OFF_STATUS) return RESP_OKAY;
    else                                             return RESP_SLVERR;
  endfunction

  // next-state for both channels; write commits one cycle after AW and W are both held
  always_comb begin
    w_aw_full_n = r_aw_full;
    w_awaddr_n  = r_awaddr;
    w_w_full_n  = r_w_full;
    w_wdata_n   = r_wdata;
    w_wstrb0_n  = r_wstrb0;
    w_bvalid_n  = r_bvalid;
    w_bresp_n   = r_bresp;
    w_ctrl_n    = r_ctrl;
    w_rvalid_n  = r_rvalid;
    w_rresp_n   = r_rresp;
    w_rdata_n   = r_rdata;

    if (s_axi_awvalid && r_awready) begin
      w_aw_full_n = 1'b1;
      w_awaddr_n  = s_axi_awaddr;
    end
    if (s_axi_wvalid && r_wready) begin
      w_w_full_n = 1'b1;
      w_wdata_n  = s_axi_wdata[1:0];
      w_wstrb0_n = s_axi_wstrb[0];
    end
    if (r_aw_full && r_w_full) begin
      w_aw_full_n = 1'b0;
      w_w_full_n  = 1'b0;
      w_bvalid_n  = 1'b1;
      w_bresp_n   = f_resp(r_awaddr);
      if (f_in_win(r_awaddr) && r_awaddr[15:0] == OFF_CTRL && r_wstrb0) w_ctrl_n = r_wdata;
    end
    if (r_bvalid && s_axi_bready) w_bvalid_n = 1'b0;

    // read data is taken from current registers, so a same-cycle write is not yet visible
    if (s_axi_arvalid && r_arready) begin
      w_rvalid_n = 1'b1;
      w_rresp_n  = f_resp(s_axi_araddr);
      w_rdata_n  = '0;
      if (f_in_win(s_axi_araddr)) begin
        if (s_axi_araddr[15:0] == OFF_CTRL)        w_rdata_n = {30'b0, r_ctrl};
        else if (s_axi_araddr[15:0] == OFF_STATUS) w_rdata_n = {28'b0, r_ctrl, w_core_rst_n, r_boot_done};
      end
    end
    if (r_rvalid && s_axi_rready) w_rvalid_n = 1'b0;

    w_awready_n = !w_aw_full_n && !w_bvalid_n;
    w_wready_n  = !w_w_full_n && !w_bvalid_n;
    w_arready_n = !w_rvalid_n;
  end

  // AXI state drops immediately with the peripheral reset
  always_ff @(posedge sys_clock or negedge r_periph_aresetn) begin
    if (!r_periph_aresetn) begin
      r_aw_full <= 1'b0;
      r_awaddr  <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb0  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
      r_ctrl    <= '0;
      r_rvalid  <= 1'b0;
      r_rresp   <= '0;
      r_rdata   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_arready <= 1'b0;
    end else begin
      r_aw_full <= w_aw_full_n;
      r_awaddr  <= w_awaddr_n;
      r_w_full  <= w_w_full_n;
      r_wdata   <= w_wdata_n;
      r_wstrb0  <= w_wstrb0_n;
      r_bvalid  <= w_bvalid_n;
      r_bresp   <= w_bresp_n;
      r_ctrl    <= w_ctrl_n;
      r_rvalid  <= w_rvalid_n;
      r_rresp   <= w_rresp_n;
      r_rdata   <= w_rdata_n;
      r_awready <= w_awready_n;
      r_wready  <= w_wready_n;
      r_arready <= w_arready_n;
    end
  end

  assign s_axi_awready  = r_awready;
  assign s_axi_wready   = r_wready;
  assign s_axi_bvalid   = r_bvalid;
  assign s_axi_bresp    = r_bresp;
  assign s_axi_arready  = r_arready;
  assign s_axi_rvalid   = r_rvalid;
  assign s_axi_rresp    = r_rresp;
  assign s_axi_rdata    = r_rdata;
  assign periph_aresetn = r_periph_aresetn;
  assign mprj_o         = {{2{r_boot_done}}, 34'b0, r_ctrl};

endmodule

// File: tb/tb_design1_wrapper.sv
// Directed testbench for design1_wrapper: reset sequencing, boot model,
// CTRL/STATUS register access, error responses and mid-operation resets.
module tb_design1_wrapper;

  localparam int RST_HOLD    = 16;
  localparam int BOOT_CYCLES = 1000;

  logic        sys_clock, sys_reset, resetb_0;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [37:0] mprj_o;
  logic        periph_aresetn;

  int n_vec = 0;
  int n_err = 0;

  design1_wrapper #(
    .BASE_ADDR  (32'h6000_0000),
    .RST_HOLD   (RST_HOLD),
    .BOOT_CYCLES(BOOT_CYCLES)
  ) dut (
    .sys_clock     (sys_clock),
    .sys_reset     (sys_reset),
    .resetb_0      (resetb_0),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .mprj_o        (mprj_o),
    .periph_aresetn(periph_aresetn)
  );

  initial sys_clock = 1'b0;
  always #2 sys_clock = ~sys_clock;

  // bus driver: full write, bounded wait
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit   done = 0;
    int   cyc  = 0;
    logic aw_hs, w_hs, b_hs;
    resp = 2'bxx;
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    while (!done && cyc < 30) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      b_hs  = s_axi_bvalid && s_axi_bready;
      if (b_hs) resp = s_axi_bresp;
      @(posedge sys_clock); #1;
      if (aw_hs) s_axi_awvalid = 1'b0;
      if (w_hs)  s_axi_wvalid  = 1'b0;
      if (b_hs)  done = 1;
      cyc++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL wr_timeout addr=%h: no B response within 30 cycles", addr);
    end
  endtask

  // bus driver: full read, bounded wait
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit   done = 0;
    int   cyc  = 0;
    logic ar_hs, r_hs;
    data = 'x; resp = 2'bxx;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    while (!done && cyc < 30) begin
      ar_hs = s_axi_arvalid && s_axi_arready;
      r_hs  = s_axi_rvalid && s_axi_rready;
      if (r_hs) begin data = s_axi_rdata; resp = s_axi_rresp; end
      @(posedge sys_clock); #1;
      if (ar_hs) s_axi_arvalid = 1'b0;
      if (r_hs)  done = 1;
      cyc++;
    end
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL rd_timeout addr=%h: no R response within 30 cycles", addr);
    end
  endtask

  task automatic test_reset();
    logic exp;
    sys_reset = 1'b0; resetb_0 = 1'b0;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_araddr = '0;
    repeat (50) begin
      @(posedge sys_clock); #1;
      n_vec++;
      if (mprj_o !== 38'h0 || periph_aresetn !== 1'b0) begin
        n_err++; $display("FAIL por_hold: mprj_o=%h periph=%b, want 0/0", mprj_o, periph_aresetn);
      end
    end
    n_vec++;
    if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0 || s_axi_arready !== 1'b0 ||
        s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0) begin
      n_err++; $display("FAIL por_axi_idle: aw/w/ar rdy=%b%b%b bv/rv=%b%b, want 0",
                        s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid);
    end
    sys_reset = 1'b1;
    for (int i = 1; i <= RST_HOLD + 2; i++) begin
      @(posedge sys_clock); #1;
      exp = (i == RST_HOLD + 2);
      n_vec++;
      if (periph_aresetn !== exp || mprj_o !== 38'h0) begin
        n_err++; $display("FAIL periph_release cyc=%0d: periph=%b mprj_o=%h, want %b/0",
                          i, periph_aresetn, mprj_o, exp);
      end
    end
    @(posedge sys_clock); #1;
    n_vec++;
    if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1 || s_axi_arready !== 1'b1) begin
      n_err++; $display("FAIL ready_after_reset: aw/w/ar=%b%b%b, want 111",
                        s_axi_awready, s_axi_wready, s_axi_arready);
    end
  endtask

  task automatic test_boot();
    logic [1:0]  exp;
    logic [31:0] d;
    logic [1:0]  r;
    resetb_0 = 1'b1;
    for (int i = 1; i <= BOOT_CYCLES + 2; i++) begin
      @(posedge sys_clock); #1;
      if (i >= BOOT_CYCLES + 1) begin
        exp = (i == BOOT_CYCLES + 2) ? 2'b11 : 2'b00;
        n_vec++;
        if (mprj_o[37:36] !== exp) begin
          n_err++; $display("FAIL boot_edge cyc=%0d: mprj_o[37:36]=%b, want %b", i, mprj_o[37:36], exp);
        end
      end
    end
    axi_read(32'h6000_5000, d, r);
    n_vec++;
    if (d !== 32'h3 || r !== 2'b00) begin
      n_err++; $display("FAIL status_booted: data=%h resp=%b, want 00000003/00", d, r);
    end
  endtask

  task automatic test_ctrl_rw();
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(32'h6000_7000, d, r);
    n_vec++;
    if (d !== 32'h0 || r !== 2'b00) begin
      n_err++; $display("FAIL ctrl_reset_val: data=%h resp=%b, want 0/00", d, r);
    end
    axi_write(32'h6000_7000, 32'h1, 4'hF, r);
    n_vec++;
    if (r !== 2'b00) begin n_err++; $display("FAIL ctrl_wr1_bresp: %b, want 00", r); end
    axi_read(32'h6000_7000, d, r);
    n_vec++;
    if (d !== 32'h1 || r !== 2'b00 || mprj_o[1:0] !== 2'b01) begin
      n_err++; $display("FAIL ctrl_rd1: data=%h resp=%b mprj[1:0]=%b, want 1/00/01", d, r, mprj_o[1:0]);
    end
    axi_write(32'h6000_7000, 32'h3, 4'hF, r);
    axi_read(32'h6000_7000, d, r);
    n_vec++;
    if (d !== 32'h3 || mprj_o[1:0] !== 2'b11 || mprj_o[35:2] !== 34'h0) begin
      n_err++; $display("FAIL ctrl_rd3: data=%h mprj_o=%h, want 3/..0003", d, mprj_o);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h6000_7000, 32'hFFFF_FFFC, 4'hF, r);
    axi_read(32'h6000_7000, d, r);
    n_vec++;
    if (d !== 32'h0) begin n_err++; $display("FAIL reserved_bits: data=%h, want 0", d); end
    axi_write(32'h6000_7000, 32'h2, 4'h1, r);
    axi_write(32'h6000_7000, 32'h3, 4'h0, r);
    axi_read(32'h6000_7000, d, r);
    n_vec++;
    if (d !== 32'h2) begin n_err++; $display("FAIL strb_zero: data=%h, want 2", d); end
    axi_write(32'h6000_7000, 32'hFFFF_FFFD, 4'hE, r);
    axi_read(32'h6000_7000, d, r);
    n_vec++;
    if (d !== 32'h2) begin n_err++; $display("FAIL strb_upper_only: data=%h, want 2", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(32'h6000_1234, d, r);
    n_vec++;
    if (d !== 32'h0 || r !== 2'b10) begin
      n_err++; $display("FAIL rd_slverr: data=%h resp=%b, want 0/10", d, r);
    end
    axi_read(32'h7000_7000, d, r);
    n_vec++;
    if (d !== 32'h0 || r !== 2'b11) begin
      n_err++; $display("FAIL rd_decerr: data=%h resp=%b, want 0/11", d, r);
    end
    axi_write(32'h6000_5000, 32'hFFFF_FFFF, 4'hF, r);
    n_vec++;
    if (r !== 2'b00) begin n_err++; $display("FAIL wr_status_bresp: %b, want 00", r); end
    axi_read(32'h6000_5000, d, r);
    n_vec++;
    if (d !== 32'hB || r !== 2'b00) begin
      n_err++; $display("FAIL status_after_wr: data=%h resp=%b, want 0000000b/00", d, r);
    end
    axi_write(32'h6000_1234, 32'h1, 4'hF, r);
    n_vec++;
    if (r !== 2'b10) begin n_err++; $display("FAIL wr_slverr: %b, want 10", r); end
    axi_write(32'h7000_7000, 32'h1, 4'hF, r);
    n_vec++;
    if (r !== 2'b11) begin n_err++; $display("FAIL wr_decerr: %b, want 11", r); end
    axi_read(32'h6000_7000, d, r);
    n_vec++;
    if (d !== 32'h2) begin n_err++; $display("FAIL ctrl_after_err_wr: data=%h, want 2", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [1:0]  r, wr;
    fork
      axi_write(32'h6000_7000, 32'h1, 4'h1, wr);
      axi_read(32'h6000_7000, d, r);
    join
    n_vec++;
    if (d !== 32'h2 || r !== 2'b00 || wr !== 2'b00) begin
      n_err++; $display("FAIL simul_rw: rdata=%h rresp=%b bresp=%b, want 2/00/00", d, r, wr);
    end
    axi_read(32'h6000_7000, d, r);
    n_vec++;
    if (d !== 32'h1 || mprj_o[1:0] !== 2'b01) begin
      n_err++; $display("FAIL simul_rw_after: data=%h mprj[1:0]=%b, want 1/01", d, mprj_o[1:0]);
    end
  endtask

  task automatic test_split_write();
    logic [31:0] d;
    logic [1:0]  r;
    s_axi_awaddr = 32'h6000_7000; s_axi_awvalid = 1'b1; s_axi_bready = 1'b1;
    @(posedge sys_clock); #1;
    s_axi_awvalid = 1'b0;
    repeat (3) @(posedge sys_clock);
    #1;
    n_vec++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b1) begin
      n_err++; $display("FAIL aw_only_wait: bvalid=%b awready=%b wready=%b, want 0/0/1",
                        s_axi_bvalid, s_axi_awready, s_axi_wready);
    end
    s_axi_wdata = 32'h3; s_axi_wstrb = 4'h1; s_axi_wvalid = 1'b1;
    @(posedge sys_clock); #1;
    s_axi_wvalid = 1'b0;
    @(posedge sys_clock); #1;
    n_vec++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || mprj_o[1:0] !== 2'b11) begin
      n_err++; $display("FAIL split_commit: bvalid=%b bresp=%b mprj[1:0]=%b, want 1/00/11",
                        s_axi_bvalid, s_axi_bresp, mprj_o[1:0]);
    end
    @(posedge sys_clock); #1;
    s_axi_bready = 1'b0;
    n_vec++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
      n_err++; $display("FAIL split_b_done: bvalid=%b awready=%b, want 0/1", s_axi_bvalid, s_axi_awready);
    end
    axi_read(32'h6000_7000, d, r);
    n_vec++;
    if (d !== 32'h3) begin n_err++; $display("FAIL split_readback: data=%h, want 3", d); end
  endtask

  task automatic test_core_reset();
    logic [31:0] d;
    logic [1:0]  r;
    resetb_0 = 1'b0;
    repeat (2) @(posedge sys_clock);
    #1;
    n_vec++;
    if (mprj_o[37:36] !== 2'b00 || mprj_o[1:0] !== 2'b11) begin
      n_err++; $display("FAIL core_rst_mprj: mprj_o=%h, want 0000000003", mprj_o);
    end
    axi_read(32'h6000_5000, d, r);
    n_vec++;
    if (d !== 32'hC || r !== 2'b00) begin
      n_err++; $display("FAIL core_rst_status: data=%h resp=%b, want 0000000c/00", d, r);
    end
    axi_read(32'h6000_7000, d, r);
    n_vec++;
    if (d !== 32'h3) begin n_err++; $display("FAIL core_rst_ctrl_kept: data=%h, want 3", d); end
  endtask

  task automatic test_sys_reset();
    logic [31:0] d;
    logic [1:0]  r;
    bit          stray;
    resetb_0 = 1'b1;
    s_axi_araddr = 32'h6000_7000; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    @(posedge sys_clock); #1;
    s_axi_arvalid = 1'b0;
    n_vec++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h3) begin
      n_err++; $display("FAIL r_latency: rvalid=%b rdata=%h, want 1/3", s_axi_rvalid, s_axi_rdata);
    end
    s_axi_awaddr = 32'h6000_7000; s_axi_awvalid = 1'b1;
    @(posedge sys_clock); #1;
    s_axi_awvalid = 1'b0;
    sys_reset = 1'b0;
    #1;
    n_vec++;
    if (mprj_o !== 38'h0 || periph_aresetn !== 1'b0 || s_axi_rvalid !== 1'b0 ||
        s_axi_arready !== 1'b0 || s_axi_awready !== 1'b0) begin
      n_err++; $display("FAIL sysrst_immediate: mprj_o=%h periph=%b rvalid=%b arready=%b awready=%b, want all 0",
                        mprj_o, periph_aresetn, s_axi_rvalid, s_axi_arready, s_axi_awready);
    end
    repeat (3) @(posedge sys_clock);
    #1;
    sys_reset = 1'b1; s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    s_axi_wdata = 32'h1; s_axi_wstrb = 4'h0;
    stray = 0;
    repeat (30) begin
      @(posedge sys_clock); #1;
      if (s_axi_rvalid !== 1'b0 || s_axi_bvalid !== 1'b0) stray = 1;
    end
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    n_vec++;
    if (stray) begin n_err++; $display("FAIL stray_resp_after_reset: stray=%b, want 0", stray); end
    axi_read(32'h6000_7000, d, r);
    n_vec++;
    if (d !== 32'h0 || r !== 2'b00 || mprj_o !== 38'h0) begin
      n_err++; $display("FAIL ctrl_after_sysrst: data=%h resp=%b mprj_o=%h, want 0/00/0", d, r, mprj_o);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_boot();
    test_ctrl_rw();
    test_strobe();
    test_errors();
    test_back_to_back();
    test_split_write();
    test_core_reset();
    test_sys_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/design1_wrapper.md
# design1_wrapper

Top-level FPGA wrapper for the FSIC Caravel-style SoC evaluation platform. It contains a single-clock reset controller, a firmware-boot model that signals "firmware running" on the user-project GPIO bus, and an AXI4-Lite slave register block mapped at 0x6000_0000. It sits directly below the board/testbench level and is the only block driven by the board clock and reset pins.

## Interface
Parameters:
- BASE_ADDR, 32'h6000_0000, base of the 64 KiB AXI4-Lite register window.
- RST_HOLD, 16, sys_clock cycles `periph_aresetn` stays low after `sys_reset` rises.
- BOOT_CYCLES, 1000, sys_clock cycles from core-reset release to firmware-ready.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- sys_clock  in  1  sole clock, 250 MHz nominal.
- sys_reset  in  1  asynchronous active-low system reset.
- resetb_0  in  1  active-low core (Caravel) reset, asynchronous assert, synchronized release.
- s_axi_aw{addr[31:0],valid,ready}, s_axi_w{data[31:0],strb[3:0],valid,ready}, s_axi_b{resp[1:0],valid,ready}, s_axi_ar{addr[31:0],valid,ready}, s_axi_r{data[31:0],resp[1:0],valid,ready}  AXI4-Lite slave.
- mprj_o  out  38  user-project GPIO outputs.
- periph_aresetn  out  1  synchronized peripheral reset, for observation.

## Operation
- Reset controller: `sys_reset`=0 forces `periph_aresetn`=0 asynchronously. After `sys_reset` rises, a 2-flop synchronizer is followed by a RST_HOLD-cycle counter; `periph_aresetn` then goes to 1.
- Core reset: `core_rst_n` = 2-flop-synchronized `resetb_0` AND `periph_aresetn`.
- Boot model: counter cleared while `core_rst_n`=0. It counts to BOOT_CYCLES and then sets `boot_done`=1, which is sticky until `core_rst_n` falls.
- mprj_o: [37:36]=2'b11 when `boot_done`, else 2'b00. [1:0]=CTRL[1:0]. All other bits are 0.
- Register map, decoded on addr[15:0] when addr[31:16]==BASE_ADDR[31:16]:
  - 0x7000 CTRL: R/W. Bits [1:0] are writable and honour strb[0]. Bits [31:2] read 0. Reset value 0.
  - 0x5000 STATUS: RO, {28'b0, CTRL[1:0], core_rst_n, boot_done}. Writes are ignored and respond OKAY.
  - Any other offset inside the window: read data 0, resp SLVERR (2'b10). Writes have no effect.
  - Address outside the window: resp DECERR (2'b11), read data 0.
- CTRL and the AXI state reset on `periph_aresetn`=0. `resetb_0` does not reset CTRL.

## Timing
- While `periph_aresetn`=0: all `*ready`=0, `bvalid`=`rvalid`=0, mprj_o=0, CTRL=0.
- Write channel:
  - AW and W are accepted independently; each `ready` is high while that channel has no latched beat and no B is pending.
  - Register update and `bvalid` occur one cycle after both beats are latched.
  - `bvalid` holds until `bready`. Only one write is outstanding.
- Read channel:
  - `arready`=1 when no R is pending.
  - `rvalid` is asserted the cycle after the AR handshake, with data sampled in that handshake cycle.
  - `rvalid` holds until `rready`.
- Simultaneous read and write to CTRL: the read returns the pre-write value.
- Reset asserted mid-transaction: the transaction is dropped immediately. No B/R is issued after reset release.
- `boot_done` rises BOOT_CYCLES+2 cycles after `resetb_0` rises, provided `periph_aresetn`=1.

## Test plan
- Power-on: hold `sys_reset`=0 for 200 ns, then release -> `periph_aresetn` rises RST_HOLD+2 cycles later. mprj_o=0 throughout.
- Boot: raise `resetb_0` -> mprj_o[37:36]=2'b11 after BOOT_CYCLES+2 cycles. STATUS read returns 0x3, resp OKAY.
- CTRL R/W:
  - Read 0x6000_7000 -> 0x0, OKAY.
  - Write 0x1 -> B resp OKAY. Read back -> 0x1, and mprj_o[1:0]=2'b01.
  - Write 0x3 -> read back 0x3, and mprj_o[1:0]=2'b11.
- Reserved bits and strobe:
  - Write 0xFFFF_FFFC to CTRL -> reads 0x0.
  - Write 0x3 with strb=4'b0000 -> CTRL is unchanged.
- Error responses:
  - Read 0x6000_1234 -> data 0, SLVERR.
  - Read 0x7000_7000 -> DECERR.
  - Write to STATUS -> OKAY, value unchanged.
- Reset mid-operation:
  - Drop `resetb_0` -> mprj_o[37:36]=2'b00 within 2 cycles; CTRL is retained.
  - Drop `sys_reset` -> CTRL=0, mprj_o=0 immediately.
